// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and helpers for the BCD score sequencer.
//   bcd_digit_t / bcd_score_t : one BCD digit / six packed BCD digits ([0] = ones)
//   seq_state_t               : sequencer FSM states
//   BASE_PTS[1:4]             : base points per line count, in BCD
//   bcd_add_digit()           : single-digit BCD add with carry in/out
`timescale 1ns/1ps
package score_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [5:0] bcd_score_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    LINES = 2'd2
  } seq_state_t;

  localparam bcd_score_t BCD_MAX = 24'h999999;

  localparam bcd_score_t BASE_PTS [1:4] = '{24'h000040, 24'h000100, 24'h000300, 24'h001200};

  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input bcd_digit_t a, input bcd_digit_t b,
                                               input logic cin);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj = s - 5'd10;
    if (s > 5'd9) return {1'b1, adj[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

  // Base points for a line count; zero for counts outside 1..4.
  function automatic bcd_score_t base_points(input logic [2:0] n);
    case (n)
      3'd1:    return BASE_PTS[1];
      3'd2:    return BASE_PTS[2];
      3'd3:    return BASE_PTS[3];
      3'd4:    return BASE_PTS[4];
      default: return '0;
    endcase
  endfunction

  function automatic logic lines_valid(input logic [2:0] n);
    return (n >= 3'd1) && (n <= 3'd4);
  endfunction

endpackage

// File: rtl/score_event_fifo.sv
// score_event_fifo: generic synchronous FIFO with show-ahead read data.
//   CLK, RESET_N      : clock, async active-low reset
//   flush             : synchronous empty; wins over push and pop
//   push, push_data   : write strobe/data (ignored when full)
//   pop               : read strobe (ignored when empty)
//   head              : oldest entry, valid while !empty
//   empty, full       : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
`timescale 1ns/1ps
module score_event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: queues line-clear events and applies level-scaled scoring
// to a 6-digit BCD score, one digit per clock, then updates lines and level.
//   CLK, RESET_N              : clock, async active-low reset
//   game_start                : sync clear of score/lines/level/queue (highest priority)
//   clear_valid/ready/lines   : event input; transfer when valid && ready
//   score_bcd                 : 6 BCD digits, [3:0] = ones
//   level, lines_total        : binary level and saturating line total
//   busy                      : FSM active or events queued
//   score_update              : 1-cycle pulse when an event's result lands
//   score_max                 : sticky, score pinned at 999999
//   hiscore_bcd               : best score when SCORE_HISCORE_EN is defined, else 0
// Handshake: an event transfers on any rising CLK edge where clear_valid and
// clear_ready are both high; clear_ready drops when the queue is full or
// game_start is high, and clear_valid may be held or changed freely.
// Scoring adds base(n) once per pass, level+1 passes, 6 clocks per pass.
`timescale 1ns/1ps
module score_sequencer
  import score_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int START_LEVEL = 0,
  parameter int MAX_LEVEL   = 29,
  parameter int LEVEL_LINES = 10
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        game_start,
  input  logic        clear_valid,
  output logic        clear_ready,
  input  logic [2:0]  clear_lines,
  output logic [23:0] score_bcd,
  output logic [7:0]  level,
  output logic [15:0] lines_total,
  output logic        busy,
  output logic        score_update,
  output logic        score_max,
  output logic [23:0] hiscore_bcd
);

  localparam logic [7:0]        START_LVL     = 8'(START_LEVEL);
  localparam logic [7:0]        MAX_LVL       = 8'(MAX_LEVEL);
  localparam logic signed [7:0] LEVEL_LINES_S = 8'(LEVEL_LINES);

  seq_state_t        state;
  bcd_score_t        score;
  bcd_score_t        ev_base;
  logic [2:0]        ev_lines;
  logic [2:0]        digit_idx;
  logic              carry;
  logic [7:0]        pass_cnt;
  logic signed [7:0] to_next;

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2:0]        fifo_head;

  logic [4:0]        dsum;
  logic [16:0]       lines_sum;
  logic [15:0]       lines_next;
  logic signed [7:0] to_next_dec;

  assign clear_ready = !fifo_full && !game_start;
  assign fifo_push   = clear_valid && clear_ready;
  assign fifo_pop    = (state == IDLE) && !fifo_empty && !game_start;
  assign busy        = (state != IDLE) || !fifo_empty;
  assign score_bcd   = score;

  score_event_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .flush     (game_start),
    .push      (fifo_push),
    .push_data (clear_lines),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign dsum        = bcd_add_digit(score[digit_idx], ev_base[digit_idx], carry);
  assign lines_sum   = {1'b0, lines_total} + {14'd0, ev_lines};
  assign lines_next  = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
  assign to_next_dec = to_next - $signed({5'd0, ev_lines});

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      score        <= '0;
      ev_base      <= '0;
      ev_lines     <= '0;
      digit_idx    <= '0;
      carry        <= 1'b0;
      pass_cnt     <= '0;
      level        <= START_LVL;
      lines_total  <= '0;
      to_next      <= LEVEL_LINES_S;
      score_max    <= 1'b0;
      score_update <= 1'b0;
    end else begin
      score_update <= 1'b0;
      if (game_start) begin
        state       <= IDLE;
        score       <= '0;
        digit_idx   <= '0;
        carry       <= 1'b0;
        pass_cnt    <= '0;
        level       <= START_LVL;
        lines_total <= '0;
        to_next     <= LEVEL_LINES_S;
        score_max   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              ev_lines  <= fifo_head;
              ev_base   <= base_points(fifo_head);
              pass_cnt  <= level;
              digit_idx <= '0;
              carry     <= 1'b0;
              // Out-of-range counts are consumed silently.
              if (lines_valid(fifo_head)) state <= score_max ? LINES : ADD;
            end
          end
          ADD: begin
            score[digit_idx] <= dsum[3:0];
            if (digit_idx == 3'd5) begin
              digit_idx <= '0;
              carry     <= 1'b0;
              if (dsum[4]) begin
                // Overflow past 999999: pin the score and skip remaining passes.
                score     <= BCD_MAX;
                score_max <= 1'b1;
                state     <= LINES;
              end else if (pass_cnt == 8'd0) begin
                state <= LINES;
              end else begin
                pass_cnt <= pass_cnt - 8'd1;
              end
            end else begin
              digit_idx <= digit_idx + 3'd1;
              carry     <= dsum[4];
            end
          end
          LINES: begin
            lines_total <= lines_next;
            // The countdown is frozen at the top level so it cannot wrap.
            if (level < MAX_LVL) begin
              if (to_next_dec[7] || (to_next_dec == 8'sd0)) begin
                level   <= level + 8'd1;
                to_next <= to_next_dec + LEVEL_LINES_S;
              end else begin
                to_next <= to_next_dec;
              end
            end
            score_update <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  bcd_score_t hiscore_q;

  // Packed BCD orders the same as binary, so a plain compare works.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hiscore_q <= '0;
    end else if ((state == LINES) && !game_start && (score > hiscore_q)) begin
      hiscore_q <= score;
    end
  end

  assign hiscore_bcd = hiscore_q;
`else
  assign hiscore_bcd = 24'd0;
`endif

endmodule

// File: tb/tb_score_sequencer.sv
`timescale 1ns/1ps
module tb_score_sequencer;

  localparam int MAX_LEVEL   = 29;
  localparam int LEVEL_LINES = 10;
  localparam int START_LEVEL = 0;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        game_start = 1'b0;
  logic        clear_valid = 1'b0;
  logic [2:0]  clear_lines = 3'd0;
  logic        clear_ready;
  logic [23:0] score_bcd;
  logic [7:0]  level;
  logic [15:0] lines_total;
  logic        busy;
  logic        score_update;
  logic        score_max;
  logic [23:0] hiscore_bcd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  score_sequencer dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .game_start   (game_start),
    .clear_valid  (clear_valid),
    .clear_ready  (clear_ready),
    .clear_lines  (clear_lines),
    .score_bcd    (score_bcd),
    .level        (level),
    .lines_total  (lines_total),
    .busy         (busy),
    .score_update (score_update),
    .score_max    (score_max),
    .hiscore_bcd  (hiscore_bcd)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_score, m_level, m_lines, m_to_next;
  bit m_max;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_level = START_LEVEL; m_lines = 0; m_to_next = LEVEL_LINES; m_max = 1'b0;
  endtask

  // Applies one event; reports whether it scores and its pop-to-pulse latency.
  task automatic model_event(input int n, output bit scored, output int lat);
    int base, passes;
    scored = 1'b0;
    lat = 0;
    if (n < 1 || n > 4) return;
    scored = 1'b1;
    base = (n == 1) ? 40 : (n == 2) ? 100 : (n == 3) ? 300 : 1200;
    if (m_max) begin
      lat = 2;
    end else begin
      passes = 0;
      for (int p = 0; p <= m_level; p++) begin
        passes++;
        m_score += base;
        if (m_score > 999999) begin
          m_score = 999999;
          m_max = 1'b1;
          break;
        end
      end
      lat = 6 * passes + 2;
    end
    m_lines = (m_lines + n > 65535) ? 65535 : m_lines + n;
    if (m_level < MAX_LEVEL) begin
      m_to_next -= n;
      if (m_to_next <= 0) begin
        m_level++;
        m_to_next += LEVEL_LINES;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int lines_q[$], level_q[$], lat_q[$], pc_q[$];
  bit max_q[$];
  int last_lat = -1;
  int mon_lat, mon_pc;
  bit saw_not_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flush_sb();
    exp_q.delete(); lines_q.delete(); level_q.delete();
    lat_q.delete(); pc_q.delete(); max_q.delete();
    model_reset();
  endtask

  always @(posedge CLK) begin
    #1;
    if (RESET_N && score_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual=1 expected=0 score=%h", score_bcd);
      end else begin
        check("upd_score", score_bcd, exp_q.pop_front());
        check("upd_lines", lines_total, lines_q.pop_front());
        check("upd_level", level, level_q.pop_front());
        check("upd_max", score_max, max_q.pop_front());
        mon_lat = lat_q.pop_front();
        mon_pc  = pc_q.pop_front();
        last_lat = cyc - mon_pc;
        if (mon_lat >= 0) check("upd_latency", last_lat, mon_lat);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_event(input logic [2:0] n);
    int waited;
    bit idle_before, scored;
    int lat;
    @(negedge CLK);
    clear_valid = 1'b1;
    clear_lines = n;
    waited = 0;
    while (!clear_ready && waited < 400) begin
      saw_not_ready = 1'b1;
      @(negedge CLK);
      waited++;
    end
    if (!clear_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=ready0 expected=ready1");
      clear_valid = 1'b0;
      return;
    end
    idle_before = !busy;
    @(posedge CLK);
    #1;
    clear_valid = 1'b0;
    model_event(int'(n), scored, lat);
    if (scored) begin
      exp_q.push_back(to_bcd(m_score));
      lines_q.push_back(m_lines);
      level_q.push_back(m_level);
      max_q.push_back(m_max);
      lat_q.push_back(idle_before ? lat : -1);
      pc_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy%0d pending%0d expected=idle", busy, exp_q.size());
    end
  endtask

  task automatic pulse_game_start();
    @(negedge CLK);
    game_start = 1'b1;
    @(posedge CLK);
    #1;
    game_start = 1'b0;
    flush_sb();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [2:0]  n;
    logic [23:0] score;
    int          lines;
    int          lvl;
    int          lat;   // 0: event must not produce an update
  } vec_t;

  vec_t vecs[9];
  int guard;
  logic [2:0] rn;

  initial begin
    vecs[0] = '{3'd1, 24'h000040,  1, 0,  8};
    vecs[1] = '{3'd2, 24'h000140,  3, 0,  8};
    vecs[2] = '{3'd3, 24'h000440,  6, 0,  8};
    vecs[3] = '{3'd0, 24'h000440,  6, 0,  0};
    vecs[4] = '{3'd4, 24'h001640, 10, 1,  8};
    vecs[5] = '{3'd4, 24'h004040, 14, 1, 14};
    vecs[6] = '{3'd7, 24'h004040, 14, 1,  0};
    vecs[7] = '{3'd2, 24'h004240, 16, 1, 14};
    vecs[8] = '{3'd5, 24'h004240, 16, 1,  0};

    model_reset();

    // Reset values while reset is held.
    #1;
    check("rst_score", score_bcd, 24'h0);
    check("rst_level", level, 8'(START_LEVEL));
    check("rst_lines", lines_total, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_update", score_update, 1'b0);
    check("rst_max", score_max, 1'b0);
    check("rst_ready", clear_ready, 1'b1);
    check("rst_hiscore", hiscore_bcd, 24'h0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Table-driven single events from reset.
    for (int i = 0; i < 9; i++) begin
      last_lat = -1;
      push_event(vecs[i].n);
      if (vecs[i].lat > 0) begin
        wait_idle(500);
        check("vec_latency", last_lat, vecs[i].lat);
      end else begin
        repeat (12) @(negedge CLK);
        check("vec_busy", busy, 1'b0);
      end
      check("vec_score", score_bcd, vecs[i].score);
      check("vec_lines", lines_total, vecs[i].lines);
      check("vec_level", level, vecs[i].lvl);
    end

    // Six n=4 back-to-back: level climbs to 2 mid-burst, queue fills.
    pulse_game_start();
    saw_not_ready = 1'b0;
    repeat (6) push_event(3'd4);
    wait_idle(2000);
    check("burst_score", score_bcd, 24'h012000);
    check("burst_lines", lines_total, 16'd24);
    check("burst_level", level, 8'd2);
    check("burst_full_seen", saw_not_ready, 1'b1);

    // game_start while the first of three events is in ADD.
    push_event(3'd1);
    push_event(3'd2);
    push_event(3'd3);
    @(negedge CLK);
    game_start  = 1'b1;
    clear_valid = 1'b1;
    clear_lines = 3'd4;
    #1;
    check("gs_ready_low", clear_ready, 1'b0);
    @(posedge CLK);
    #1;
    game_start  = 1'b0;
    clear_valid = 1'b0;
    flush_sb();
    check("gs_score", score_bcd, 24'h0);
    check("gs_level", level, 8'(START_LEVEL));
    check("gs_lines", lines_total, 16'h0);
    check("gs_busy", busy, 1'b0);
    check("gs_update", score_update, 1'b0);
    repeat (60) @(negedge CLK);
    check("gs_still_idle", busy, 1'b0);
    check("gs_score_hold", score_bcd, 24'h0);

    // Randomized events against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) rn = 3'($urandom_range(1, 4));
      else                          rn = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      push_event(rn);
      if ($urandom_range(0, 3) == 0) wait_idle(3000);
      else repeat ($urandom_range(0, 5)) @(negedge CLK);
    end
    wait_idle(5000);
    check("rnd_score", score_bcd, to_bcd(m_score));
    check("rnd_lines", lines_total, m_lines);
    check("rnd_level", level, m_level);

    // Asynchronous reset in the middle of ADD.
    push_event(3'd2);
    repeat (3) @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_score", score_bcd, 24'h0);
    check("mid_rst_level", level, 8'(START_LEVEL));
    check("mid_rst_lines", lines_total, 16'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_update", score_update, 1'b0);
    flush_sb();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_ready", clear_ready, 1'b1);
    check("mid_rst_idle", busy, 1'b0);

    // High score across a game_start.
    push_event(3'd1);
    wait_idle(500);
    check("hi_first", hiscore_bcd, HI_EN ? 24'h000040 : 24'h0);
    pulse_game_start();
    check("hi_keep", hiscore_bcd, HI_EN ? 24'h000040 : 24'h0);
    push_event(3'd2);
    wait_idle(500);
    check("hi_score", score_bcd, 24'h000100);
    check("hi_second", hiscore_bcd, HI_EN ? 24'h000100 : 24'h0);

    // Saturation: n=4 until pinned, then events add lines only.
    pulse_game_start();
    guard = 0;
    while (!m_max && guard < 300) begin
      push_event(3'd4);
      guard++;
    end
    push_event(3'd4);
    push_event(3'd3);
    wait_idle(30000);
    check("sat_score", score_bcd, 24'h999999);
    check("sat_max", score_max, 1'b1);
    check("sat_lines", lines_total, m_lines);
    last_lat = -1;
    push_event(3'd1);
    wait_idle(500);
    check("sat_skip_latency", last_lat, 2);
    check("sat_hold", score_bcd, 24'h999999);
    pulse_game_start();
    check("sat_clear", score_max, 1'b0);
    check("sat_clear_score", score_bcd, 24'h0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
